wb_port_arbiter: RTL and testbench

//  Shares the single writeback/ROB write port between N execution pipes (ALU, MEM, MUL-M5, ...).

---
 rtl/wb_arb_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_wb_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter slice.
// Supplies default widths (overridable through the WORD_SIZE and
// INSTR_TYPE_SZ macros), the packet layout and a saturating counter helper.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif

package wb_arb_pkg;

  localparam int WB_WORD_SIZE     = `WORD_SIZE;
  localparam int WB_INSTR_TYPE_SZ = `INSTR_TYPE_SZ;
  localparam int ROB_ID_W         = 7;
  localparam int N_REQ_DEF        = 3;
  localparam int GRANT_W          = $clog2(N_REQ_DEF);

  localparam logic [15:0] PERF_CNT_MAX = 16'hFFFF;

  // One writeback packet at the default widths.
  typedef struct packed {
    logic [WB_INSTR_TYPE_SZ-1:0] instr_type;
    logic [WB_WORD_SIZE-1:0]     pc;
    logic [WB_WORD_SIZE-1:0]     result;
    logic [ROB_ID_W-1:0]         rob_id;
  } wb_pkt_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == PERF_CNT_MAX) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: starting at ptr, returns the first
// asserted request searching upward and wrapping from N-1 back to 0.
// Output is a one-hot grant plus its binary index; grant_any flags a hit.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int pos;

  // Walk the requests in rotated order and latch the first one found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!grant_any && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
        grant_any  = 1'b1;
      end else begin
        grant_any  = grant_any;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single writeback/ROB write port between N_REQ execution pipes.
// One packet per cycle is granted round-robin and registered into the WB
// output stage (1-cycle latency). Downstream stalls (wb_ready=0) freeze the
// stage; flush kills the staged packet without disturbing the pointer.
// Optional: define WB_ARB_PERF_EN to add per-pipe conflict counters.
module wb_port_arbiter #(
  parameter int N_REQ         = wb_arb_pkg::N_REQ_DEF,
  parameter int WORD_SIZE     = wb_arb_pkg::WB_WORD_SIZE,
  parameter int INSTR_TYPE_SZ = wb_arb_pkg::WB_INSTR_TYPE_SZ,
  parameter int ROB_ID_W      = wb_arb_pkg::ROB_ID_W,
  localparam int GW           = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*INSTR_TYPE_SZ-1:0] req_instr_type,
  input  logic [N_REQ*WORD_SIZE-1:0]     req_pc,
  input  logic [N_REQ*WORD_SIZE-1:0]     req_result,
  input  logic [N_REQ*ROB_ID_W-1:0]      req_rob_id,
  input  logic                           wb_ready,
  output logic                           valid_out,
  output logic [INSTR_TYPE_SZ-1:0]       instruction_type_out,
  output logic [WORD_SIZE-1:0]           pc_out,
  output logic [WORD_SIZE-1:0]           result_out,
  output logic [ROB_ID_W-1:0]            rob_id_out,
  output logic [GW-1:0]                  grant_id_out
`ifdef WB_ARB_PERF_EN
  ,output logic [N_REQ*16-1:0]           conflict_cnt
`endif
);

  logic [GW-1:0]            ptr;
  logic [GW-1:0]            ptr_next;
  logic [N_REQ-1:0]         grant;
  logic [GW-1:0]            grant_idx;
  logic                     grant_any;
  logic                     load;
  logic                     arb_en;
  logic                     transfer;
  logic [INSTR_TYPE_SZ-1:0] sel_instr_type;
  logic [WORD_SIZE-1:0]     sel_pc;
  logic [WORD_SIZE-1:0]     sel_result;
  logic [ROB_ID_W-1:0]      sel_rob_id;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The stage can take a new packet when empty or being drained this cycle.
  assign load      = !valid_out || wb_ready;
  assign arb_en    = load && !flush && !reset;
  assign req_ready = arb_en ? grant : '0;
  assign transfer  = arb_en && grant_any;
  assign ptr_next  = (grant_idx == GW'(N_REQ - 1)) ? '0 : grant_idx + GW'(1);

  // Steer the granted pipe's packet fields toward the output register.
  always_comb begin
    sel_instr_type = req_instr_type[int'(grant_idx)*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
    sel_pc         = req_pc[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
    sel_result     = req_result[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
    sel_rob_id     = req_rob_id[int'(grant_idx)*ROB_ID_W +: ROB_ID_W];
  end

  // WB stage register and round-robin pointer; reset > flush > transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out            <= 1'b0;
      instruction_type_out <= '0;
      pc_out               <= '0;
      result_out           <= '0;
      rob_id_out           <= '0;
      grant_id_out         <= '0;
      ptr                  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (transfer) begin
      valid_out            <= 1'b1;
      instruction_type_out <= sel_instr_type;
      pc_out               <= sel_pc;
      result_out           <= sel_result;
      rob_id_out           <= sel_rob_id;
      grant_id_out         <= grant_idx;
      ptr                  <= ptr_next;
    end else if (load) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_out;
    end
  end

`ifdef WB_ARB_PERF_EN
  // Count, per pipe, cycles spent offering a packet that was not taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          conflict_cnt[i*16 +: 16] <= wb_arb_pkg::sat_inc16(conflict_cnt[i*16 +: 16]);
        end else begin
          conflict_cnt[i*16 +: 16] <= conflict_cnt[i*16 +: 16];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (N_REQ=3): a vector table for the
// cycle-by-cycle arbitration plus short sequences for flush, streaming,
// reset-over-flush and (with WB_ARB_PERF_EN) the conflict counters.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int W  = WB_WORD_SIZE;
  localparam int IT = WB_INSTR_TYPE_SZ;
  localparam int R  = ROB_ID_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IT-1:0] req_instr_type;
  logic [N*W-1:0]  req_pc;
  logic [N*W-1:0]  req_result;
  logic [N*R-1:0]  req_rob_id;
  logic            wb_ready;
  logic            valid_out;
  logic [IT-1:0]   instruction_type_out;
  logic [W-1:0]    pc_out;
  logic [W-1:0]    result_out;
  logic [R-1:0]    rob_id_out;
  logic [1:0]      grant_id_out;
`ifdef WB_ARB_PERF_EN
  logic [N*16-1:0] conflict_cnt;
`endif

  logic [IT-1:0] p_it  [N];
  logic [W-1:0]  p_pc  [N];
  logic [W-1:0]  p_res [N];
  logic [R-1:0]  p_rob [N];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         rst;
    logic         fl;
    logic [2:0]   rv;
    logic         wb;
    logic [2:0]   rdy;
    logic         v;
    logic [R-1:0] rob;
    logic [1:0]   gid;
    logic [W-1:0] pc;
  } vec_t;

  vec_t tbl [18];

  assign req_instr_type = {p_it[2], p_it[1], p_it[0]};
  assign req_pc         = {p_pc[2], p_pc[1], p_pc[0]};
  assign req_result     = {p_res[2], p_res[1], p_res[0]};
  assign req_rob_id     = {p_rob[2], p_rob[1], p_rob[0]};

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .flush                (flush),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_instr_type       (req_instr_type),
    .req_pc               (req_pc),
    .req_result           (req_result),
    .req_rob_id           (req_rob_id),
    .wb_ready             (wb_ready),
    .valid_out            (valid_out),
    .instruction_type_out (instruction_type_out),
    .pc_out               (pc_out),
    .result_out           (result_out),
    .rob_id_out           (rob_id_out),
    .grant_id_out         (grant_id_out)
`ifdef WB_ARB_PERF_EN
    ,.conflict_cnt        (conflict_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, then check the combinational ready shortly after.
  task automatic drive(input logic rst, input logic fl, input logic [2:0] rv,
                       input logic wb, input logic [2:0] exp_rdy, input string tag);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    req_valid = rv;
    wb_ready  = wb;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
  endtask

  // Step past the rising edge and check the registered WB stage.
  task automatic after_edge(input logic exp_v, input logic [R-1:0] exp_rob,
                            input logic [1:0] exp_gid, input string tag);
    @(posedge clk);
    #1;
    chk({tag, " valid_out"}, 64'(valid_out), 64'(exp_v));
    chk({tag, " rob_id_out"}, 64'(rob_id_out), 64'(exp_rob));
    chk({tag, " grant_id_out"}, 64'(grant_id_out), 64'(exp_gid));
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic [2:0] rv,
                              input logic wb, input logic [2:0] rdy, input logic v,
                              input int rob, input int gid, input int pc);
    vec_t t;
    t.rst = rst; t.fl = fl; t.rv = rv; t.wb = wb;
    t.rdy = rdy; t.v = v; t.rob = R'(rob); t.gid = 2'(gid); t.pc = W'(pc);
    return t;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 3'b000; wb_ready = 1'b1;
    p_it[0] = IT'(1);      p_it[1] = IT'(2);      p_it[2] = IT'(3);
    p_pc[0] = W'(32'h100); p_pc[1] = W'(32'h200); p_pc[2] = W'(32'h300);
    p_res[0] = W'(32'hA0); p_res[1] = W'(32'hB1); p_res[2] = W'(32'hC2);
    p_rob[0] = R'(5);      p_rob[1] = R'(9);      p_rob[2] = R'(12);

    //             rst   fl    rv      wb    rdy     v    rob gid pc
    tbl[0]  = mk(1'b1, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 0,  0, 'h000); // reset, all valid
    tbl[1]  = mk(1'b1, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 0,  0, 'h000);
    tbl[2]  = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5,  0, 'h100); // contention 0,1,2,0
    tbl[3]  = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 9,  1, 'h200);
    tbl[4]  = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 12, 2, 'h300);
    tbl[5]  = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 5,  0, 'h100);
    tbl[6]  = mk(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 5,  0, 'h100); // backpressure x3
    tbl[7]  = mk(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 5,  0, 'h100);
    tbl[8]  = mk(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 5,  0, 'h100);
    tbl[9]  = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 9,  1, 'h200); // resumes at pipe 1
    tbl[10] = mk(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 9,  1, 'h200); // idle: data holds
    tbl[11] = mk(1'b0, 1'b0, 3'b011, 1'b1, 3'b001, 1'b1, 5,  0, 'h100); // ptr 2 wraps to 0
    tbl[12] = mk(1'b0, 1'b0, 3'b011, 1'b1, 3'b010, 1'b1, 9,  1, 'h200);
    tbl[13] = mk(1'b0, 1'b1, 3'b010, 1'b1, 3'b000, 1'b0, 9,  1, 'h200); // flush blocks grant
    tbl[14] = mk(1'b0, 1'b0, 3'b010, 1'b1, 3'b010, 1'b1, 9,  1, 'h200); // ptr stayed 2
    tbl[15] = mk(1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 1'b1, 5,  0, 'h100); // ptr 2, only req0
    tbl[16] = mk(1'b0, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 9,  1, 'h200); // proves ptr became 1
    tbl[17] = mk(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 9,  1, 'h200);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].rv, tbl[i].wb, tbl[i].rdy, $sformatf("vec%0d", i));
      after_edge(tbl[i].v, tbl[i].rob, tbl[i].gid, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d pc_out", i), 64'(pc_out), 64'(tbl[i].pc));
    end

    // Flush of a staged packet (rob 20) while the port is stalled.
    p_rob[1] = R'(20);
    drive(1'b0, 1'b0, 3'b010, 1'b1, 3'b010, "fl_load");
    after_edge(1'b1, R'(20), 2'd1, "fl_load");
    drive(1'b0, 1'b1, 3'b010, 1'b0, 3'b000, "fl_kill");
    after_edge(1'b0, R'(20), 2'd1, "fl_kill");
    chk("fl_kill result_out holds", 64'(result_out), 64'(p_res[1]));
    drive(1'b0, 1'b0, 3'b111, 1'b1, 3'b100, "fl_resume");
    after_edge(1'b1, R'(12), 2'd2, "fl_resume");
    chk("fl_resume result_out", 64'(result_out), 64'(p_res[2]));

    // Single requester streams every cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b010, 1'b1, 3'b010, $sformatf("stream%0d", i));
      after_edge(1'b1, R'(20), 2'd1, $sformatf("stream%0d", i));
      chk($sformatf("stream%0d instr_type", i), 64'(instruction_type_out), 64'(p_it[1]));
    end

    // Reset wins over flush and clears the stage.
    drive(1'b1, 1'b1, 3'b111, 1'b1, 3'b000, "rst_fl");
    after_edge(1'b0, R'(0), 2'd0, "rst_fl");
    chk("rst_fl pc_out", 64'(pc_out), 64'd0);
    chk("rst_fl result_out", 64'(result_out), 64'd0);

`ifdef WB_ARB_PERF_EN
    // Counters restart from the reset above: grants 0,1 then two stalled cycles.
    drive(1'b0, 1'b0, 3'b111, 1'b1, 3'b001, "perf0");
    after_edge(1'b1, R'(5), 2'd0, "perf0");
    drive(1'b0, 1'b0, 3'b111, 1'b1, 3'b010, "perf1");
    after_edge(1'b1, R'(20), 2'd1, "perf1");
    drive(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, "perf2");
    after_edge(1'b1, R'(20), 2'd1, "perf2");
    drive(1'b0, 1'b0, 3'b111, 1'b0, 3'b000, "perf3");
    after_edge(1'b1, R'(20), 2'd1, "perf3");
    drive(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, "perf4");
    after_edge(1'b1, R'(20), 2'd1, "perf4");
    chk("conflict_cnt[0]", 64'(conflict_cnt[15:0]), 64'd3);
    chk("conflict_cnt[1]", 64'(conflict_cnt[31:16]), 64'd3);
    chk("conflict_cnt[2]", 64'(conflict_cnt[47:32]), 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
